// File: rtl/sr_chk_pkg.sv
// Shared definitions for the SR flip-flop checker.
//   sr_state_e      : golden-model tracking state (reset / tracking / unknown)
//   POLICY_UNKNOWN  : after s=r=1 the expected q is undefined; comparisons pause
//   POLICY_TOGGLE   : after s=r=1 the expected q toggles (JK-equivalent)
//   DEFAULT_CNT_W   : default width of the saturating event counters
package sr_chk_pkg;

    typedef enum logic [1:0] {
        StReset   = 2'd0,
        StTrack   = 2'd1,
        StUnknown = 2'd2
    } sr_state_e;

    localparam int unsigned POLICY_UNKNOWN = 0;
    localparam int unsigned POLICY_TOGGLE  = 1;
    localparam int unsigned DEFAULT_CNT_W  = 8;

endpackage

// File: rtl/sr_ref_model.sv
// Cycle-accurate golden SR flip-flop with a small tracking FSM.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (expected q forced to 0)
//   s, r    : set / reset requests as driven to the flop under check
//   exp_q   : expected flop output for the current cycle
//   exp_vld : exp_q is defined (low while the state is unknown after s=r=1)
module sr_ref_model
    import sr_chk_pkg::*;
#(
    parameter int unsigned ILLEGAL_POLICY = POLICY_UNKNOWN
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic exp_q,
    output logic exp_vld
);

    sr_state_e state_q, state_d;
    logic      exp_q_q, exp_q_d;

    always_comb begin
        state_d = state_q;
        exp_q_d = exp_q_q;
        case (state_q)
            StReset, StTrack: begin
                state_d = StTrack;
                case ({s, r})
                    2'b10: exp_q_d = 1'b1;
                    2'b01: exp_q_d = 1'b0;
                    2'b11: begin
                        if (ILLEGAL_POLICY == POLICY_TOGGLE) begin
                            exp_q_d = ~exp_q_q;
                        end else begin
                            state_d = StUnknown;
                        end
                    end
                    default: ;
                endcase
            end
            StUnknown: begin
                // Only a clean set or reset re-establishes a known value.
                if (s ^ r) begin
                    state_d = StTrack;
                    exp_q_d = s;
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReset;
            exp_q_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q_q <= exp_q_d;
        end
    end

    assign exp_q   = exp_q_q;
    assign exp_vld = (state_q != StUnknown);

endmodule

// File: rtl/sr_ff_checker.sv
// Self-checking monitor for an SR flip-flop stage. Runs a golden model on the
// same stimulus and compares the flop's q/qb one edge after the stimulus.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   s, r         : stimulus as driven to the flop
//   q, qb        : flop outputs under check
//   exp_q        : golden expected q for the current cycle
//   exp_vld      : exp_q is defined and compared this cycle
//   err          : one-cycle pulse on a mismatch or complement violation
//   err_sticky   : set by any err, cleared only by rst
//   err_cnt      : saturating count of err pulses
//   illegal      : one-cycle pulse after s=r=1 is sampled
//   illegal_cnt  : saturating count of illegal requests
module sr_ff_checker
    import sr_chk_pkg::*;
#(
    parameter int unsigned CNT_W          = DEFAULT_CNT_W,
    parameter int unsigned ILLEGAL_POLICY = POLICY_UNKNOWN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qb,
    output logic             exp_q,
    output logic             exp_vld,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W-1:0] CntOne = 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             mismatch;
    logic             err_d, illegal_d;
    logic             err_q, err_sticky_q, illegal_q;
    logic [CNT_W-1:0] err_cnt_q, illegal_cnt_q;

    sr_ref_model #(
        .ILLEGAL_POLICY(ILLEGAL_POLICY)
    ) u_ref (
        .clk    (clk),
        .rst    (rst),
        .s      (s),
        .r      (r),
        .exp_q  (exp_q),
        .exp_vld(exp_vld)
    );

    // Case inequality makes an X/Z on q or qb count as a mismatch in simulation;
    // in hardware it reduces to an ordinary compare. exp_q is the pre-update value.
    always_comb begin
        mismatch  = (q !== exp_q) || (qb !== ~q);
        err_d     = exp_vld && mismatch;
        illegal_d = s && r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q         <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_cnt_q     <= '0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            illegal_q <= illegal_d;
            if (err_d) begin
                err_sticky_q <= 1'b1;
            end
            if (err_d && (err_cnt_q != CntMax)) begin
                err_cnt_q <= err_cnt_q + CntOne;
            end
            if (illegal_d && (illegal_cnt_q != CntMax)) begin
                illegal_cnt_q <= illegal_cnt_q + CntOne;
            end
        end
    end

    assign err         = err_q;
    assign err_sticky  = err_sticky_q;
    assign err_cnt     = err_cnt_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
module tb_sr_ff_checker;
    import sr_chk_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       s = 1'b0;
    logic       r = 1'b0;
    logic [2:0] q_in = '0;
    logic [2:0] qb_in = '1;
    logic [2:0] exp_q_w, exp_vld_w, err_w, sticky_w, ill_w;
    logic [7:0] ecnt0, icnt0, ecnt1, icnt1;
    logic [1:0] ecnt2, icnt2;

    // dut0: policy unknown, 8-bit counters; dut1: toggle policy; dut2: 2-bit counters
    sr_ff_checker #(.CNT_W(8), .ILLEGAL_POLICY(POLICY_UNKNOWN)) dut0 (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q_in[0]), .qb(qb_in[0]),
        .exp_q(exp_q_w[0]), .exp_vld(exp_vld_w[0]), .err(err_w[0]),
        .err_sticky(sticky_w[0]), .err_cnt(ecnt0), .illegal(ill_w[0]),
        .illegal_cnt(icnt0)
    );
    sr_ff_checker #(.CNT_W(8), .ILLEGAL_POLICY(POLICY_TOGGLE)) dut1 (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q_in[1]), .qb(qb_in[1]),
        .exp_q(exp_q_w[1]), .exp_vld(exp_vld_w[1]), .err(err_w[1]),
        .err_sticky(sticky_w[1]), .err_cnt(ecnt1), .illegal(ill_w[1]),
        .illegal_cnt(icnt1)
    );
    sr_ff_checker #(.CNT_W(2), .ILLEGAL_POLICY(POLICY_UNKNOWN)) dut2 (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q_in[2]), .qb(qb_in[2]),
        .exp_q(exp_q_w[2]), .exp_vld(exp_vld_w[2]), .err(err_w[2]),
        .err_sticky(sticky_w[2]), .err_cnt(ecnt2), .illegal(ill_w[2]),
        .illegal_cnt(icnt2)
    );

    int n_tests = 0;
    int n_fail = 0;

    // Behavioural model: m_exp = -1 means the expected value is unknown.
    int pol[3]  = '{0, 1, 0};
    int cmax[3] = '{255, 255, 3};
    int fq[3];      // the bench's own flop, drives q/qb
    int m_exp[3], m_err[3], m_sticky[3], m_ecnt[3], m_ill[3], m_icnt[3];

    function automatic int ecnt_of(input int i);
        if (i == 0) return int'(ecnt0);
        if (i == 1) return int'(ecnt1);
        return int'(ecnt2);
    endfunction

    function automatic int icnt_of(input int i);
        if (i == 0) return int'(icnt0);
        if (i == 1) return int'(icnt1);
        return int'(icnt2);
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input int i, input int t_rst, input int t_s, input int t_r,
                              input int qv, input int qbv);
        int e;
        if (t_rst != 0) begin
            m_exp[i] = 0; m_err[i] = 0; m_sticky[i] = 0;
            m_ecnt[i] = 0; m_ill[i] = 0; m_icnt[i] = 0;
        end else begin
            e = (m_exp[i] >= 0 && (qv != m_exp[i] || qbv == qv)) ? 1 : 0;
            m_err[i] = e;
            if (e != 0) begin
                m_sticky[i] = 1;
                m_ecnt[i] = (m_ecnt[i] < cmax[i]) ? m_ecnt[i] + 1 : cmax[i];
            end
            m_ill[i] = (t_s != 0 && t_r != 0) ? 1 : 0;
            if (m_ill[i] != 0) m_icnt[i] = (m_icnt[i] < cmax[i]) ? m_icnt[i] + 1 : cmax[i];
            if (t_s != 0 && t_r == 0) m_exp[i] = 1;
            else if (t_s == 0 && t_r != 0) m_exp[i] = 0;
            else if (t_s != 0 && t_r != 0) m_exp[i] = (pol[i] == 1) ? 1 - m_exp[i] : -1;
        end
    endtask

    // fault: 0 none, 1 q inverted, 2 qb equal to q
    task automatic tick(input int t_rst, input int t_s, input int t_r, input int fault);
        int qv, qbv;
        rst = (t_rst != 0);
        s   = (t_s != 0);
        r   = (t_r != 0);
        for (int i = 0; i < 3; i++) begin
            qv  = fq[i];
            qbv = 1 - fq[i];
            if (fault == 1) qv = 1 - qv;
            if (fault == 2) qbv = qv;
            q_in[i]  = (qv != 0);
            qb_in[i] = (qbv != 0);
            model_step(i, t_rst, t_s, t_r, qv, qbv);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (t_rst != 0) fq[i] = 0;
            else if (t_s != 0 && t_r == 0) fq[i] = 1;
            else if (t_s == 0 && t_r != 0) fq[i] = 0;
            else if (t_s != 0 && t_r != 0) fq[i] = 1 - fq[i];
            check($sformatf("dut%0d exp_vld", i), int'(exp_vld_w[i]), (m_exp[i] >= 0) ? 1 : 0);
            if (m_exp[i] >= 0) check($sformatf("dut%0d exp_q", i), int'(exp_q_w[i]), m_exp[i]);
            check($sformatf("dut%0d err", i), int'(err_w[i]), m_err[i]);
            check($sformatf("dut%0d err_sticky", i), int'(sticky_w[i]), m_sticky[i]);
            check($sformatf("dut%0d err_cnt", i), ecnt_of(i), m_ecnt[i]);
            check($sformatf("dut%0d illegal", i), int'(ill_w[i]), m_ill[i]);
            check($sformatf("dut%0d illegal_cnt", i), icnt_of(i), m_icnt[i]);
        end
    endtask

    typedef struct {
        int rst, s, r, fault;
        int exp_q, exp_vld, err, sticky, ill, ecnt, icnt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        for (int i = 0; i < 3; i++) begin
            fq[i] = 0; m_exp[i] = 0; m_err[i] = 0; m_sticky[i] = 0;
            m_ecnt[i] = 0; m_ill[i] = 0; m_icnt[i] = 0;
        end

        // Directed vectors for dut0 (policy unknown); values are after the edge.
        //           rst s r flt  q vld err stk ill ecnt icnt
        vecs[0]  = '{1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 1,  1, 1, 1, 1, 0, 1, 0};
        vecs[10] = '{0, 0, 0, 0,  1, 1, 0, 1, 0, 1, 0};
        vecs[11] = '{1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 1, 1, 0,  0, 0, 0, 0, 1, 0, 1};
        vecs[13] = '{0, 1, 1, 0,  0, 0, 0, 0, 1, 0, 2};
        vecs[14] = '{0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 2};
        vecs[15] = '{0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 2};

        for (int k = 0; k < 16; k++) begin
            tick(vecs[k].rst, vecs[k].s, vecs[k].r, vecs[k].fault);
            check($sformatf("vec%0d exp_vld", k), int'(exp_vld_w[0]), vecs[k].exp_vld);
            if (vecs[k].exp_vld != 0)
                check($sformatf("vec%0d exp_q", k), int'(exp_q_w[0]), vecs[k].exp_q);
            check($sformatf("vec%0d err", k), int'(err_w[0]), vecs[k].err);
            check($sformatf("vec%0d err_sticky", k), int'(sticky_w[0]), vecs[k].sticky);
            check($sformatf("vec%0d illegal", k), int'(ill_w[0]), vecs[k].ill);
            check($sformatf("vec%0d err_cnt", k), int'(ecnt0), vecs[k].ecnt);
            check($sformatf("vec%0d illegal_cnt", k), int'(icnt0), vecs[k].icnt);
        end

        // Toggle policy: from q=0, two illegal requests give 1 then 0, no err.
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0);
        check("pol1 exp_q first", int'(exp_q_w[1]), 1);
        check("pol1 err first", int'(err_w[1]), 0);
        tick(0, 1, 1, 0);
        check("pol1 exp_q second", int'(exp_q_w[1]), 0);
        check("pol1 err second", int'(err_w[1]), 0);
        tick(0, 0, 0, 0);
        check("pol1 err after", int'(err_w[1]), 0);
        check("pol1 illegal_cnt", int'(icnt1), 2);

        // Saturation: qb stuck equal to q on the 2-bit counter instance.
        tick(1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            tick(0, 0, 0, 2);
            check($sformatf("sat err k=%0d", k), int'(err_w[2]), 1);
            check($sformatf("sat err_cnt k=%0d", k), int'(ecnt2), (k < 3) ? k : 3);
        end

        // Random stimulus against the model.
        tick(1, 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            tick(($urandom % 25 == 0) ? 1 : 0, int'($urandom % 2), int'($urandom % 2),
                 ($urandom % 8 == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_ff_checker.md
Name: sr_ff_checker

Overview:
- Self-checking monitor placed directly downstream of the SR-from-JK flip-flop stage.
- Consumes the same s, r and rst stimulus plus the flop's q/qb outputs, and runs a cycle-accurate golden SR model.
- Flags mismatches, complement violations and illegal S=R=1 requests, and keeps saturating counters for bench sign-off and later on-chip use.

Parameters:
- CNT_W, 8, width of the error and illegal counters (saturating).
- ILLEGAL_POLICY, 0, expected q after S=R=1: 0 = unknown (comparisons suspended), 1 = toggle (JK-equivalent).

Ports:
- clk  input  1  rising-edge clock shared with the flop under check.
- rst  input  1  synchronous, active-high reset; resets the checker and defines the flop's expected q=0.
- s  input  1  set request as driven to the flop.
- r  input  1  reset request as driven to the flop.
- q  input  1  flop output under check.
- qb  input  1  flop complement output under check.
- exp_q  output  1  golden expected q for the current cycle.
- exp_vld  output  1  exp_q is defined and being compared this cycle.
- err  output  1  one-cycle pulse on a detected mismatch.
- err_sticky  output  1  set by any err; cleared only by rst.
- err_cnt  output  CNT_W  number of err pulses, saturating at all-ones.
- illegal  output  1  one-cycle pulse the cycle after s=r=1 is sampled with rst=0.
- illegal_cnt  output  CNT_W  number of illegal events, saturating.

Behaviour:
- Clock, reset and sampling:
  - One clock; reset is synchronous and active-high; all registers update only on posedge clk.
  - s, r and rst are sampled at posedge N. The flop's response is visible on q/qb before posedge N+1 and is compared at posedge N+1. Latency from stimulus to err is 1 cycle after the edge that captures q.
- Reset values (rst=1 at a posedge): exp_q=0, exp_vld=1 (state RESET), err=0, err_sticky=0, err_cnt=0, illegal=0, illegal_cnt=0. Reset has priority over every other event, including mid-sequence and during an illegal request.
- States:
  - RESET: entered on rst. With rst=0, moves to TRACK and applies the golden update.
  - TRACK: compares q and qb every cycle.
  - UNKNOWN: entered only when ILLEGAL_POLICY=0 and s=r=1 is sampled. exp_vld=0 and no compare. Leaves to TRACK on the first sample with s^r=1 (exp_q=s) or rst=1 (to RESET). Samples with s=r=0 or s=r=1 stay in UNKNOWN.
- Golden update (rst=0, state RESET or TRACK):
  - s=0, r=0: hold.
  - s=1, r=0: exp_q=1.
  - s=0, r=1: exp_q=0.
  - s=1, r=1: toggle (policy 1) or go to UNKNOWN (policy 0). illegal pulses in either policy.
- Compare (exp_vld=1 at posedge, rst=0):
  - err=1 if q != exp_q or qb != ~q. Both faults in the same cycle give one err pulse and one count.
  - The compare uses exp_q as it stood before this edge's update.
- Counters: increment by exactly 1 per event and hold at 2^CNT_W-1. err and illegal on the same cycle increment their counters independently.
- Output registers: all outputs are registered; no combinational path from inputs to outputs.
- Unknown inputs: an X/Z on q or qb while exp_vld=1 counts as a mismatch (err=1). This is a simulation-only intent; synthesis treats it as a normal compare.

Decomposition:
- Shared package sr_chk_pkg holds:
  - the state enum (RESET, TRACK, UNKNOWN);
  - constants POLICY_UNKNOWN=0 and POLICY_TOGGLE=1;
  - the default CNT_W.
- One natural sub-module, sr_ref_model, contains the golden flop and state FSM, with outputs exp_q and exp_vld. The top level holds the compare logic, sticky flag and saturating counters.

Test Plan:
- Reset then hold: rst=1 for 2 cycles, then s,r=00 for 3 cycles with a correct flop. Required: exp_q=0, exp_vld=1, err_cnt=0, illegal_cnt=0 throughout.
- Set/reset sequence: s,r = 10, 00, 01, 10, one cycle each. Required: exp_q = 1, 1, 0, 1 and no err.
- Injected fault: force q=0 one cycle after s,r=10. Required: err pulses for exactly 1 cycle, err_sticky=1, err_cnt=1. A later rst clears all three.
- Illegal, policy 0: s,r=11 for 2 cycles, then 10. Required: illegal pulses on both cycles, illegal_cnt=2, exp_vld=0 during UNKNOWN, no err, then exp_vld=1 and exp_q=1.
- Illegal, policy 1: from q=0, s,r=11 for 2 cycles. Required: exp_q goes 1 then 0, flop outputs compared each cycle, and a flop toggling the same way gives no err.
- Saturation and complement: CNT_W=2; hold qb=q (complement fault) for 6 cycles. Required: err_cnt stops at 3 and err keeps pulsing each cycle.
